// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;
    typedef logic [15:0] reg_value_t;
    localparam reg_value_t INST_NOP = 16'h0800;
    localparam logic [4:0] OP_B = 5'b00010;
    typedef enum logic {
        FETCH_BOOT,
        FETCH_RUN
    } fetch_state_e;
endpackage

// File: rtl/inst_fetch_next_pc.sv
// fetch_next_pc: sequential next PC, plus early resolution of unconditional B
// when FETCH_EARLY_BRANCH_EN is defined.
module fetch_next_pc
    import inst_fetch_pkg::*;
(
    input  reg_value_t pc_i,
    input  reg_value_t mem_data_i,
    output reg_value_t next_pc_o,
    output logic       taken_o
);
`ifdef FETCH_EARLY_BRANCH_EN
    assign taken_o   = mem_data_i[15:11] == OP_B;
    assign next_pc_o = pc_i + 16'd1 + (taken_o ? {{5{mem_data_i[10]}}, mem_data_i[10:0]} : 16'd0);
`else
    logic unused_mem_data;
    assign unused_mem_data = ^mem_data_i;
    assign taken_o   = 1'b0;
    assign next_pc_o = pc_i + 16'd1;
`endif
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, instruction-memory address and IF/ID register with stall and
// redirect handling; FETCH_EARLY_BRANCH_EN enables fetch-time resolution of B.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter reg_value_t RESET_PC = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       branch_en,
    input  reg_value_t branch_target,
    output reg_value_t mem_addr,
    input  reg_value_t mem_data,
    output reg_value_t if_pc,
    output reg_value_t if_inst,
    output logic       if_valid,
    output logic       if_pred_taken
);
    fetch_state_e state_q, state_d;
    reg_value_t   pc_q, pc_d, if_pc_q, if_pc_d, if_inst_q, if_inst_d, npc;
    logic         if_valid_q, if_valid_d, if_pred_q, if_pred_d, taken;

    fetch_next_pc u_next_pc (
        .pc_i      (pc_q),
        .mem_data_i(mem_data),
        .next_pc_o (npc),
        .taken_o   (taken)
    );

    always_comb begin
        state_d    = FETCH_RUN;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        if_pred_d  = if_pred_q;
        if (state_q == FETCH_RUN) begin
            // A redirect overrides stall: the wrong-path word is squashed to a bubble.
            if (branch_en) begin
                pc_d       = branch_target;
                if_inst_d  = INST_NOP;
                if_valid_d = 1'b0;
                if_pred_d  = 1'b0;
            end else if (!stall) begin
                pc_d       = npc;
                if_pc_d    = pc_q;
                if_inst_d  = mem_data;
                if_valid_d = 1'b1;
                if_pred_d  = taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH_BOOT;
            pc_q       <= RESET_PC;
            if_pc_q    <= 16'h0000;
            if_inst_q  <= INST_NOP;
            if_valid_q <= 1'b0;
            if_pred_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            if_pred_q  <= if_pred_d;
        end
    end

    assign mem_addr      = pc_q;
    assign if_pc         = if_pc_q;
    assign if_inst       = if_inst_q;
    assign if_valid      = if_valid_q;
    assign if_pred_taken = if_pred_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vectors against a combinational memory model.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] mem_addr, mem_data, if_pc, if_inst;
    logic        if_valid, if_pred_taken;
    int          n_vec = 0;
    int          n_err = 0;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid),
        .if_pred_taken(if_pred_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h690a;
            16'h0001: return 16'h6a0c;
            16'h0002: return 16'h6b90;
            16'h0003: return 16'h3360;
            16'h0004: return 16'hdb20;
            16'h0009: return 16'h10f7;
            16'h0020: return 16'h7a5c;
            default:  return 16'h6000;
        endcase
    endfunction

    assign mem_data = mem_f(mem_addr);

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"}, mem_addr, 16'h0000);
        chk({tag, "_pc"}, if_pc, 16'h0000);
        chk({tag, "_inst"}, if_inst, 16'h0800);
        chk({tag, "_valid"}, {15'd0, if_valid}, 16'd0);
        chk({tag, "_pred"}, {15'd0, if_pred_taken}, 16'd0);
    endtask

    initial begin
        #12;
        chk_reset("rst");
        rst = 1'b1;
        step();
        chk("boot_valid", {15'd0, if_valid}, 16'd0);
        chk("boot_inst", if_inst, 16'h0800);
        chk("boot_addr", mem_addr, 16'h0000);
        step();
        chk("e2_pc", if_pc, 16'h0000);
        chk("e2_inst", if_inst, 16'h690a);
        chk("e2_valid", {15'd0, if_valid}, 16'd1);
        step();
        chk("seq1_inst", if_inst, 16'h6a0c);
        chk("seq1_pc", if_pc, 16'h0001);
        step();
        chk("seq2_inst", if_inst, 16'h6b90);
        chk("seq2_pc", if_pc, 16'h0002);
        step();
        chk("seq3_inst", if_inst, 16'h3360);
        chk("seq3_pc", if_pc, 16'h0003);
        chk("seq3_addr", mem_addr, 16'h0004);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", mem_addr, 16'h0004);
            chk("stall_pc", if_pc, 16'h0003);
            chk("stall_inst", if_inst, 16'h3360);
        end
        stall = 1'b0;
        step();
        chk("unstall_pc", if_pc, 16'h0004);
        chk("unstall_inst", if_inst, 16'hdb20);
        branch_en = 1'b1;
        branch_target = 16'h0020;
        stall = 1'b1;
        step();
        branch_en = 1'b0;
        stall = 1'b0;
        chk("br_addr", mem_addr, 16'h0020);
        chk("br_valid", {15'd0, if_valid}, 16'd0);
        chk("br_inst", if_inst, 16'h0800);
        step();
        chk("tgt_pc", if_pc, 16'h0020);
        chk("tgt_inst", if_inst, 16'h7a5c);
        chk("tgt_valid", {15'd0, if_valid}, 16'd1);
        branch_en = 1'b1;
        branch_target = 16'hffff;
        step();
        branch_en = 1'b0;
        chk("wrap_pre", mem_addr, 16'hffff);
        step();
        chk("wrap_addr", mem_addr, 16'h0000);
        chk("wrap_pc", if_pc, 16'hffff);
        branch_en = 1'b1;
        branch_target = 16'h0009;
        step();
        branch_en = 1'b0;
        chk("eb_pre", mem_addr, 16'h0009);
        step();
        chk("eb_inst", if_inst, 16'h10f7);
        chk("eb_pc", if_pc, 16'h0009);
`ifdef FETCH_EARLY_BRANCH_EN
        chk("eb_addr", mem_addr, 16'h0101);
        chk("eb_pred", {15'd0, if_pred_taken}, 16'd1);
`else
        chk("eb_addr", mem_addr, 16'h000a);
        chk("eb_pred", {15'd0, if_pred_taken}, 16'd0);
`endif
        #2;
        branch_en = 1'b1;
        branch_target = 16'h0040;
        rst = 1'b0;
        #1;
        chk_reset("arst");
        @(negedge clk);
        branch_en = 1'b0;
        rst = 1'b1;
        step();
        chk("reboot_valid", {15'd0, if_valid}, 16'd0);
        chk("reboot_addr", mem_addr, 16'h0000);
        step();
        chk("reboot_inst", if_inst, 16'h690a);
        chk("reboot_valid2", {15'd0, if_valid}, 16'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the 16-bit pipelined CPU. It is the initiator on the instruction-memory interface: it holds the PC, drives the word address to `inst_mem_ctrl`, samples the returned word in the same cycle, and registers it with its PC into the IF/ID pipeline register. It handles pipeline stalls and branch redirects from later stages and, optionally, resolves unconditional `B` branches early at fetch.

## Interface
- `RESET_PC`, default `16'h0000`: PC loaded at reset.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC and IF/ID (load-use or structural hazard).
- `branch_en`  in  1  redirect request from EX.
- `branch_target`  in  16  redirect address, valid when `branch_en`.
- `mem_addr`  out  16  word address to instruction memory.
- `mem_data`  in  16  instruction word, combinational response to `mem_addr` in the same cycle.
- `if_pc`  out  16  PC of the instruction in IF/ID.
- `if_inst`  out  16  instruction in IF/ID.
- `if_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `if_pred_taken`  out  1  fetch already redirected on this instruction.

## Operation
- Registers: `pc`, `state`, IF/ID (`if_pc`, `if_inst`, `if_valid`, `if_pred_taken`).
- `mem_addr` = `pc` combinationally; there is no other path to memory.
- States:
  - `BOOT`: entered on reset. For one cycle `pc` = `RESET_PC` is presented, IF/ID stays a bubble, then the block moves to `RUN`.
  - `RUN`: normal fetch. There is no exit except reset.
- Per-edge priority in `RUN`:
  1. `branch_en`:
     - `pc` <= `branch_target`.
     - IF/ID <= bubble (`if_inst` = NOP `16'h0800`, `if_valid` = 0, `if_pred_taken` = 0).
     - `stall` is ignored this cycle.
  2. `stall`: all registers hold.
  3. Otherwise:
     - IF/ID <= {`pc`, `mem_data`, valid = 1}.
     - `pc` <= next PC.
- Next PC is `pc + 1`, modulo 2^16: `16'hFFFF` wraps to `16'h0000`.
- No branch delay slot. The wrong-path word fetched during the redirect cycle is always squashed.
- A bubble always carries `if_inst` = `16'h0800`, so downstream decode needs no special case.
- `rst` asserted mid-operation clears all registers immediately (asynchronous) and returns to `BOOT`. Any pending branch is discarded.

## Timing
- Reset values:
  - `pc` = `RESET_PC`, `state` = `BOOT`.
  - `if_pc` = `16'h0000`, `if_inst` = `16'h0800`, `if_valid` = 0, `if_pred_taken` = 0.
- Fetch latency: the word at address A appears on `if_inst` one edge after `mem_addr` = A.
- First valid instruction: `if_valid` = 1 on the 2nd rising edge after `rst` deasserts.
- Branch penalty: one bubble.
  - The edge with `branch_en` loads the target.
  - The next edge loads the target instruction into IF/ID.
- Throughput: one instruction per cycle when neither `stall` nor `branch_en` is active.

## Configuration
- `FETCH_EARLY_BRANCH_EN` defined:
  - Applies only in case 3 (no branch, no stall) when `mem_data[15:11]` = `5'b00010` (unconditional `B`).
  - Next PC = `pc + 1 + sext(mem_data[10:0])`, 16-bit modulo.
  - The `B` itself is still written to IF/ID, with `if_pred_taken` = 1.
  - EX must not redirect on a `B` carrying `if_pred_taken`.
- `FETCH_EARLY_BRANCH_EN` undefined:
  - Next PC is always `pc + 1`.
  - `if_pred_taken` is tied to 0.
  - The adder and sign-extension logic are absent.

## Structure
- `define.v` holds:
  - `RegValue`, the 16-bit value range.
  - `INST_NOP` = `16'h0800`.
  - `OP_B` = `5'b00010`.
  - The state encodings `FETCH_BOOT` / `FETCH_RUN`.
- One sub-module, `fetch_next_pc`: combinational, takes `pc` and `mem_data`, produces next PC and the taken flag. Its early-branch logic is compiled under the macro.

## Test plan
- Reset/boot: release `rst` with memory returning `16'h690a` at 0 → edge 1: `if_valid` = 0, `if_inst` = `16'h0800`; edge 2: `if_pc` = 0, `if_inst` = `16'h690a`, `if_valid` = 1.
- Sequential fetch: memory 1→`16'h6a0c`, 2→`16'h6b90`, 3→`16'h3360` → `if_inst` sequence `6a0c`, `6b90`, `3360` on consecutive edges, with `if_pc` = 1, 2, 3.
- Stall: assert `stall` for 3 cycles while `pc` = 4 → `mem_addr` stays 4 and IF/ID is unchanged; after release, `if_pc` = 4, `if_inst` = `16'hdb20`.
- Branch plus simultaneous stall: `branch_en` = 1, `branch_target` = `16'h0020`, `stall` = 1 → next edge `mem_addr` = `16'h0020`, `if_valid` = 0, `if_inst` = `16'h0800`.
- Wrap and async reset: `pc` = `16'hFFFF` → next `mem_addr` = `16'h0000`; then pulse `rst` low mid-cycle → outputs immediately return to reset values.
- Early branch (macro on): `pc` = 9, `mem_data` = `16'h10f7` → next `mem_addr` = `16'h0101` and `if_pred_taken` = 1. With the macro off, next `mem_addr` = `16'h000a` and `if_pred_taken` = 0.
